// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the alu16 datapath ALU: opcode
//                encodings, default operand width and status-register bit
//                positions.
//  Contents    : ALU_ADD/ALU_SUB/ALU_AND/ALU_NOTB opcodes, DEF_WIDTH,
//                STAT_Z/STAT_N/STAT_V indices, alu_op_t alias.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [1:0] alu_op_t;

    // Opcode map
    localparam alu_op_t ALU_ADD  = 2'b00;
    localparam alu_op_t ALU_SUB  = 2'b01;
    localparam alu_op_t ALU_AND  = 2'b10;
    localparam alu_op_t ALU_NOTB = 2'b11;

    // Default operand/result width
    localparam int DEF_WIDTH = 16;

    // Bit positions inside the 3-bit status word {V,N,Z}
    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu16_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_if
//  Description : Operand/result bundle between the register-file operand
//                latches, the ALU and the result latch.
//  Signals     : Ain, Bin, ALUop, load_status  (driven by master)
//                out, Z, N, V, status          (driven by the ALU, slave)
//  Modports    : master - operand source / result consumer
//                slave  - the ALU itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu16_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    alu_op_t          ALUop;
    logic             load_status;
    logic [WIDTH-1:0] out;
    logic             Z;
    logic             N;
    logic             V;
    logic [2:0]       status;

    modport master (
        output Ain, Bin, ALUop, load_status,
        input  out, Z, N, V, status
    );

    modport slave (
        input  Ain, Bin, ALUop, load_status,
        output out, Z, N, V, status
    );

endinterface : alu16_if
`default_nettype wire

// File: rtl/alu16_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_addsub
//  Description : Single shared adder for ADD and SUB. Subtraction is done as
//                A + ~B + 1, so one carry chain serves both operations.
//  Ports       : i_a, i_b  - operands
//                i_sub     - 1 selects A - B, 0 selects A + B
//                o_sum     - result modulo 2^WIDTH (carry-out discarded)
//                o_ovf     - signed two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module alu16_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_sub,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_cin;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_cin   = {{(WIDTH-1){1'b0}}, i_sub};
    assign o_sum   = i_a + w_b_eff + w_cin;

    // Overflow happens when the adder's two inputs agree in sign and the sum
    // disagrees. Using the inverted B covers the SUB case (operand signs
    // differ, result sign differs from A) with the same expression.
    assign o_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule : alu16_addsub
`default_nettype wire

// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
//  Module      : alu16
//  Description : 16-bit datapath ALU. Combinational ADD/SUB/AND/NOT-B result
//                with combinational Z/N/V flags, plus a clocked status
//                register that captures {V,N,Z} when load_status is high.
//  Ports       : clk    - rising-edge clock (status register only)
//                rst_n  - asynchronous active-low reset, clears status only
//                bus    - alu16_if.slave: Ain, Bin, ALUop, load_status in;
//                         out, Z, N, V, status out
//  Revision    : 1.0 - initial release
// ============================================================================
module alu16
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu16_if.slave    bus
);

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_sub;
    logic             w_arith;
    logic [WIDTH-1:0] w_out;
    logic             w_z;
    logic             w_n;
    logic             w_v;
    logic [2:0]       r_status;

    assign w_sub   = (bus.ALUop == ALU_SUB);
    assign w_arith = (bus.ALUop == ALU_ADD) || (bus.ALUop == ALU_SUB);

    alu16_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a   (bus.Ain),
        .i_b   (bus.Bin),
        .i_sub (w_sub),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Result mux. NOT-B takes only Bin, so an undriven Ain cannot leak into
    // the result. An unknown opcode yields X in simulation and is a
    // don't-care for synthesis.
    always_comb begin
        w_out = {WIDTH{1'bx}};
        case (bus.ALUop)
            ALU_ADD:  w_out = w_sum;
            ALU_SUB:  w_out = w_sum;
            ALU_AND:  w_out = bus.Ain & bus.Bin;
            ALU_NOTB: w_out = ~bus.Bin;
            default:  w_out = {WIDTH{1'bx}};
        endcase
    end

    assign w_z = (w_out == {WIDTH{1'b0}});
    assign w_n = w_out[WIDTH-1];
    // Overflow is meaningful only for arithmetic; the adder still sees
    // operands during logic ops, so its flag is masked here.
    assign w_v = w_arith ? w_ovf : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 3'b000;
        end else if (bus.load_status) begin
            r_status[STAT_V] <= w_v;
            r_status[STAT_N] <= w_n;
            r_status[STAT_Z] <= w_z;
        end
    end

    assign bus.out    = w_out;
    assign bus.Z      = w_z;
    assign bus.N      = w_n;
    assign bus.V      = w_v;
    assign bus.status = r_status;

endmodule : alu16
`default_nettype wire

// File: tb/tb_alu16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu16
//  Description : Self-checking bench for alu16. Directed vector table for the
//                combinational path, hand-written sequences for the status
//                register and reset, and a random sweep against an
//                integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu16;
    import alu_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic         exp_z;
        logic         exp_n;
        logic         exp_v;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu16_if #(.WIDTH(W)) bus ();

    alu16 #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_comb(input string name, input logic [W-1:0] eo,
                              input logic ez, input logic en, input logic ev);
        n_vec++;
        if (bus.out !== eo || bus.Z !== ez || bus.N !== en || bus.V !== ev) begin
            n_err++;
            $display("FAIL %s: got out=%h Z=%b N=%b V=%b, expected out=%h Z=%b N=%b V=%b",
                     name, bus.out, bus.Z, bus.N, bus.V, eo, ez, en, ev);
        end
    endtask

    task automatic check_status(input string name, input logic [2:0] es);
        n_vec++;
        if (bus.status !== es) begin
            n_err++;
            $display("FAIL %s: got status=%b, expected status=%b", name, bus.status, es);
        end
    endtask

    // Independent model: signed integer arithmetic, overflow by range check.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] o,
                                  output logic z, output logic n, output logic v);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 0;
        v  = 1'b0;
        case (op)
            2'd0: begin r = sa + sb; v = (r > 32767) || (r < -32768); end
            2'd1: begin r = sa - sb; v = (r > 32767) || (r < -32768); end
            2'd2: r = int'(a & b);
            default: r = int'(~b);
        endcase
        o = r[W-1:0];
        z = (o == 16'h0000);
        n = o[W-1];
    endfunction

    task automatic apply(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.ALUop = op;
        bus.Ain   = a;
        bus.Bin   = b;
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] mo;
        logic         mz, mn, mv;
        n_vec = 0;
        n_err = 0;

        vecs.push_back('{ALU_ADD,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{ALU_SUB,  16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{ALU_AND,  16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{ALU_NOTB, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{ALU_ADD,  16'h0002, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ALU_SUB,  16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ALU_AND,  16'h0002, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ALU_NOTB, 16'h0002, 16'h5555, 16'hAAAA, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{ALU_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{ALU_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{ALU_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{ALU_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{ALU_SUB,  16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{ALU_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{ALU_AND,  16'hFFFF, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{ALU_NOTB, 16'hxxxx, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0});

        // Reset asserted with load requested and Z=1: status must stay 0.
        rst_n = 1'b0;
        bus.load_status = 1'b1;
        apply(ALU_SUB, 16'h0005, 16'h0005);
        #1;
        check_status("reset_async", 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check_status("reset_priority", 3'b000);
        check_comb("comb_during_reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        apply(ALU_ADD, 16'h0002, 16'h0001);
        #1;
        check_comb("track_during_reset", 16'h0003, 1'b0, 1'b0, 1'b0);

        // Directed combinational table
        bus.load_status = 1'b0;
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check_comb($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_z,
                       vecs[i].exp_n, vecs[i].exp_v);
        end

        // Status register sequence
        @(negedge clk);
        rst_n = 1'b1;
        apply(ALU_SUB, 16'h0005, 16'h0005);
        bus.load_status = 1'b1;
        @(posedge clk);
        #1;
        check_status("load_sub55", 3'b001);
        @(negedge clk);
        bus.load_status = 1'b0;
        apply(ALU_ADD, 16'h7FFF, 16'h0001);
        @(posedge clk);
        #1;
        check_status("hold_no_load", 3'b001);
        @(negedge clk);
        bus.load_status = 1'b1;
        @(posedge clk);
        #1;
        check_status("load_ovf", 3'b110);
        @(negedge clk);
        apply(ALU_SUB, 16'h0000, 16'h0001);
        @(posedge clk);
        #1;
        check_status("load_neg", 3'b010);

        // Asynchronous reset mid-cycle, away from any edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("reset_midcycle", 3'b000);
        check_comb("comb_after_reset", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.load_status = 1'b0;

        // Random sweep
        for (int k = 0; k < 1000; k++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            apply(rop, ra, rb);
            #1;
            model(rop, ra, rb, mo, mz, mn, mv);
            check_comb($sformatf("rand%0d op=%0d a=%h b=%h", k, rop, ra, rb), mo, mz, mn, mv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu16
`default_nettype wire
